// File: rtl/pipelined_cla_adder_if.sv
// rtl/pipelined_cla_adder_if.sv - operand/result handshake bundle for pipelined_cla_adder
interface pipelined_cla_adder_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - segmented carry-lookahead add/sub, one stage per SEG bits
// Optional feature: CLA_PIPE_SAT_EN clamps s to the signed range on overflow.
module pipelined_cla_adder #(
  parameter int N   = 32,
  parameter int SEG = 8
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int STAGES = N / SEG;
  localparam int L      = STAGES - 1;

  // Lookahead carries c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0, built as sum of products.
  function automatic logic [SEG:0] seg_carries(input logic [SEG-1:0] x,
                                               input logic [SEG-1:0] y,
                                               input logic           c0);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < SEG; i++) begin
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (g[j] & pp);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (c0 & pp);
    end
    return c;
  endfunction

  logic [N-1:0] a_i [STAGES];
  logic [N-1:0] b_i [STAGES];
  logic [N-1:0] s_i [STAGES];
  logic         c_i [STAGES];
  logic         v_i [STAGES];

  logic [N-1:0] a_q [STAGES];
  logic [N-1:0] b_q [STAGES];
  logic [N-1:0] s_q [STAGES];
  logic         c_q [STAGES];
  logic         m_q [STAGES];
  logic         v_q [STAGES];

  logic [N-1:0] s_d [STAGES];
  logic         c_d [STAGES];
  logic         m_d [STAGES];
  logic [SEG:0] cc;
  logic         en;
  logic         ovf_w;

  // Whole pipe advances or freezes together, so bubbles are never squeezed out.
  assign en = bus.out_ready | ~v_q[L];

  // Subtraction folds into the adder as a + ~b + 1; the inversion travels with the beat.
  always_comb begin
    a_i[0] = bus.a;
    b_i[0] = bus.sub ? ~bus.b : bus.b;
    s_i[0] = '0;
    c_i[0] = bus.sub | bus.cin;
    v_i[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      s_i[k] = s_q[k-1];
      c_i[k] = c_q[k-1];
      v_i[k] = v_q[k-1];
    end
  end

  always_comb begin
    cc = '0;
    for (int k = 0; k < STAGES; k++) begin
      cc     = seg_carries(a_i[k][k*SEG +: SEG], b_i[k][k*SEG +: SEG], c_i[k]);
      s_d[k] = s_i[k];
      s_d[k][k*SEG +: SEG] = a_i[k][k*SEG +: SEG] ^ b_i[k][k*SEG +: SEG] ^ cc[SEG-1:0];
      c_d[k] = cc[SEG];
      m_d[k] = cc[SEG-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_i[k];
        a_q[k] <= a_i[k];
        b_q[k] <= b_i[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        m_q[k] <= m_d[k];
      end
    end
  end

  assign ovf_w         = c_q[L] ^ m_q[L];
  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[L];
  assign bus.cout      = c_q[L];
  assign bus.ovf       = ovf_w;

`ifdef CLA_PIPE_SAT_EN
  // On overflow the wrapped sign is the opposite of the true sign.
  assign bus.s = ovf_w ? (s_q[L][N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}})
                       : s_q[L];
`else
  assign bus.s = s_q[L];
`endif
endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter N, default 32, operand/result width in bits; N SHALL be a positive multiple of SEG.
REQ-002 Parameter SEG, default 8, segment width; one pipeline stage per segment, STAGES = N/SEG.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a, b  input  N  operands.
REQ-008 cin  input  1  carry-in, add mode only.
REQ-009 sub  input  1  0 = a+b+cin, 1 = a-b (a + ~b + 1, cin ignored).
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 s  output  N  sum/difference.
REQ-013 cout  output  1  carry out of bit N-1 (add: unsigned carry; sub: 1 = no borrow).
REQ-014 ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-015 Beat transfers at input when in_valid & in_ready, at output when out_valid & out_ready.
REQ-016 Stage k (0..STAGES-1) SHALL add bits [k*SEG +: SEG] using carry registered from stage k-1; stage 0 uses cin (add) or 1 (sub).
REQ-017 Upper operand segments SHALL be delayed and lower result segments skewed so s, cout, ovf of one beat appear together.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall.
REQ-019 Throughput SHALL be one beat per cycle when out_ready is held 1.
REQ-020 Stall: when out_valid & !out_ready, every stage SHALL hold its contents; in_ready = out_ready | !out_valid.
REQ-021 Bubbles (invalid stages) SHALL propagate without affecting s/cout/ovf of valid beats; pipeline SHALL NOT compact bubbles while stalled.
REQ-022 Each stage segment logic SHALL compute generate/propagate and carry in lookahead form within the segment.
REQ-023 ovf = (carry into bit N-1) XOR (carry out of bit N-1).
REQ-024 Results SHALL be bit-exact modulo 2^N for all a, b, cin, sub, including all-ones and zero operands.
REQ-025 Simultaneous input and output transfer in the same cycle SHALL be lossless.
REQ-026 s, cout, ovf SHALL hold stable while out_valid & !out_ready.

Reset
REQ-027 On rst=1 at a rising edge, all stage valid bits, out_valid, s, cout, ovf SHALL become 0.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; no partial result is ever presented.
REQ-029 in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-030 In-flight data registers other than valid bits need not be reset.

Configuration
REQ-031 Macro CLA_PIPE_SAT_EN defined: when ovf=1, s SHALL clamp to 2^(N-1)-1 if the true result is positive, -2^(N-1) if negative; ovf and cout unchanged.
REQ-032 CLA_PIPE_SAT_EN undefined: s is the wrapped modulo-2^N result; saturation logic absent.

Verification (N=32, SEG=8)
REQ-033 a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0 -> s=0x0000_0100, cout=0, ovf=0, out_valid exactly 4 cycles after transfer.
REQ-034 a=0xFFFF_FFFF, b=0, cin=1 -> s=0, cout=1, ovf=0 (full carry ripple across all stages).
REQ-035 a=0x7FFF_FFFF, b=1, sub=0 -> ovf=1; s=0x8000_0000 without macro, 0x7FFF_FFFF with CLA_PIPE_SAT_EN.
REQ-036 a=5, b=7, sub=1 -> s=0xFFFF_FFFE, cout=0, ovf=0; a=0x8000_0000, b=1, sub=1 -> ovf=1.
REQ-037 10 back-to-back beats, out_ready low for cycles 3-6 after first output -> all 10 results in order, none lost or duplicated, in_ready low during stall while out_valid high.
REQ-038 rst asserted with 3 beats in flight -> out_valid=0 next cycle and those beats never appear.
